axel_mem_test: RTL and testbench

//  Memory-test processing element between two streaming memory adapters (sma, one per bank).

---
 rtl/axel_mem_test_pkg.sv | 21 ++
 rtl/axel_mem_test_chan.sv | 78 +++++++
 rtl/axel_mem_test.sv | 46 ++++
 tb/tb_axel_mem_test.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/axel_mem_test_pkg.sv
// Shared constants and the per-lane increment used by both memory-test channels.
package axel_mem_test_pkg;

  localparam int DATA_WIDTH        = 128;
  localparam int LANE_WIDTH        = 32;
  localparam int NUM_LANES         = DATA_WIDTH / LANE_WIDTH;
  localparam int LANE_INC_DEFAULT  = 1;
  localparam int BUF_DEPTH_DEFAULT = 2;

  // Adds inc to every lane independently; each lane wraps on its own, with no carry between lanes.
  function automatic logic [DATA_WIDTH-1:0] lane_inc(input logic [DATA_WIDTH-1:0] word,
                                                     input logic [LANE_WIDTH-1:0] inc);
    logic [DATA_WIDTH-1:0] res;
    res = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      res[k*LANE_WIDTH +: LANE_WIDTH] = word[k*LANE_WIDTH +: LANE_WIDTH] + inc;
    end
    return res;
  endfunction

endpackage

// File: rtl/axel_mem_test_chan.sv
// One memory-test channel: pops words from a read stream, increments every lane,
// buffers the result in a small circular buffer and pushes it to the write stream.
//
// Handshakes: a read-stream word is consumed on a rising edge where rd & vld are
// both 1 (rd is only raised when vld is 1). A write-stream word is delivered on a
// rising edge where wr is 1; wr is only raised while full is 0, and data_out holds
// its value until the word has been pushed.
module axel_mem_test_chan
  import axel_mem_test_pkg::*;
#(
  parameter int LANE_INC  = LANE_INC_DEFAULT,
  parameter int BUF_DEPTH = BUF_DEPTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vld,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  rd,
  input  logic                  full,
  output logic                  wr,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);

  localparam logic [CW-1:0]         FULL_CNT = CW'(BUF_DEPTH);
  localparam logic [PW-1:0]         LAST_PTR = PW'(BUF_DEPTH - 1);
  localparam logic [LANE_WIDTH-1:0] INC      = LANE_WIDTH'(LANE_INC);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [CW-1:0]         count;
  logic                  pop;
  logic                  push;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Pop while there is room, push while something is buffered and the sink accepts; both held off in reset.
  always_comb begin
    pop      = 1'b0;
    push     = 1'b0;
    pop      = reset & vld & (count < FULL_CNT);
    push     = reset & (count != '0) & ~full;
    rd       = pop;
    wr       = push;
    data_out = mem[head];
  end

  // Circular buffer: transformed word enters at the tail, leaves from the head.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int k = 0; k < BUF_DEPTH; k++) begin
        mem[k] <= '0;
      end
    end else begin
      if (pop) begin
        mem[tail] <= lane_inc(data_in, INC);
        tail      <= next_ptr(tail);
      end
      if (push) begin
        head <= next_ptr(head);
      end
      case ({pop, push})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axel_mem_test.sv
// Memory-test processing element: two independent channels, one per memory bank.
module axel_mem_test
  import axel_mem_test_pkg::*;
#(
  parameter int LANE_INC  = LANE_INC_DEFAULT,
  parameter int BUF_DEPTH = BUF_DEPTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vld0,
  input  logic [DATA_WIDTH-1:0] data_in0,
  output logic                  rd0,
  input  logic                  full0,
  output logic                  wr0,
  output logic [DATA_WIDTH-1:0] data_out0,
  input  logic                  vld1,
  input  logic [DATA_WIDTH-1:0] data_in1,
  output logic                  rd1,
  input  logic                  full1,
  output logic                  wr1,
  output logic [DATA_WIDTH-1:0] data_out1
);

  axel_mem_test_chan #(.LANE_INC(LANE_INC), .BUF_DEPTH(BUF_DEPTH)) u_chan0 (
    .clk      (clk),
    .reset    (reset),
    .vld      (vld0),
    .data_in  (data_in0),
    .rd       (rd0),
    .full     (full0),
    .wr       (wr0),
    .data_out (data_out0)
  );

  axel_mem_test_chan #(.LANE_INC(LANE_INC), .BUF_DEPTH(BUF_DEPTH)) u_chan1 (
    .clk      (clk),
    .reset    (reset),
    .vld      (vld1),
    .data_in  (data_in1),
    .rd       (rd1),
    .full     (full1),
    .wr       (wr1),
    .data_out (data_out1)
  );

endmodule

// File: tb/tb_axel_mem_test.sv
// Directed bench for axel_mem_test: drivers push hand-computed expected words into
// per-channel queues on acceptance; a monitor pops and compares on every push.
module tb_axel_mem_test;

  logic         clk = 1'b0;
  logic         reset;
  logic         vld0, vld1, full0, full1;
  logic [127:0] data_in0, data_in1;
  logic         rd0, rd1, wr0, wr1;
  logic [127:0] data_out0, data_out1;

  logic [127:0] exp_q0[$];
  logic [127:0] exp_q1[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int wr_cnt0 = 0, wr_cnt1 = 0;
  int last_wr_cyc0 = 0, last_wr_cyc1 = 0;
  int last_rd_cyc0 = 0;
  int acc0 = 0;
  logic [127:0] mon_e0, mon_e1;

  axel_mem_test dut (
    .clk       (clk),
    .reset     (reset),
    .vld0      (vld0),
    .data_in0  (data_in0),
    .rd0       (rd0),
    .full0     (full0),
    .wr0       (wr0),
    .data_out0 (data_out0),
    .vld1      (vld1),
    .data_in1  (data_in1),
    .rd1       (rd1),
    .full1     (full1),
    .wr1       (wr1),
    .data_out1 (data_out1)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: protocol rules plus scoreboard pops on every push
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      check("rd0_needs_vld0", rd0 & ~vld0, 128'd0);
      check("rd1_needs_vld1", rd1 & ~vld1, 128'd0);
      check("wr0_while_full0", wr0 & full0, 128'd0);
      check("wr1_while_full1", wr1 & full1, 128'd0);
    end
    if (wr0 === 1'b1) begin
      wr_cnt0++;
      last_wr_cyc0 = cyc;
      if (exp_q0.size() == 0) begin
        check("wr0_unexpected", data_out0, 128'hx);
      end else begin
        mon_e0 = exp_q0.pop_front();
        check("data_out0", data_out0, mon_e0);
      end
    end
    if (wr1 === 1'b1) begin
      wr_cnt1++;
      last_wr_cyc1 = cyc;
      if (exp_q1.size() == 0) begin
        check("wr1_unexpected", data_out1, 128'hx);
      end else begin
        mon_e1 = exp_q1.pop_front();
        check("data_out1", data_out1, mon_e1);
      end
    end
  end

  // driver: present one word, wait (bounded) for the pop, record its expected result
  task automatic send_word(input int ch, input logic [127:0] word, input logic [127:0] exp,
                           output int waited);
    bit done;
    done   = 1'b0;
    waited = 0;
    if (ch == 0) begin data_in0 = word; vld0 = 1'b1; end
    else         begin data_in1 = word; vld1 = 1'b1; end
    while (!done) begin
      @(negedge clk);
      if ((ch == 0 && rd0 === 1'b1) || (ch == 1 && rd1 === 1'b1)) begin
        if (ch == 0) begin exp_q0.push_back(exp); last_rd_cyc0 = cyc; end
        else exp_q1.push_back(exp);
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 50) begin
          n_cmp++;
          n_err++;
          $display("FAIL pop_timeout ch%0d: got no rd, required rd within 50 cycles", ch);
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
      if (done && ch == 0) acc0++;
    end
  endtask

  task automatic stream(input int ch, input int n, input logic [31:0] base);
    int w;
    for (int i = 0; i < n; i++) begin
      logic [31:0] b;
      b = base + 32'(4 * i);
      send_word(ch, {b + 32'd3, b + 32'd2, b + 32'd1, b},
                    {b + 32'd4, b + 32'd3, b + 32'd2, b + 32'd1}, w);
    end
    if (ch == 0) vld0 = 1'b0;
    else         vld1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, s, snap0, snap1;
    reset = 1'b0; vld0 = 1'b1; vld1 = 1'b1; full0 = 1'b0; full1 = 1'b0;
    data_in0 = 128'h11111111_22222222_33333333_44444444;
    data_in1 = 128'h55555555_66666666_77777777_88888888;

    // reset held 3 cycles with vld asserted
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_rd0", rd0, 128'd0);
      check("rst_rd1", rd1, 128'd0);
      check("rst_wr0", wr0, 128'd0);
      check("rst_wr1", wr1, 128'd0);
      check("rst_data_out0", data_out0, 128'd0);
      check("rst_data_out1", data_out1, 128'd0);
    end
    @(posedge clk); #1;
    reset = 1'b1; vld0 = 1'b0; vld1 = 1'b0;
    repeat (2) @(posedge clk); #1;

    // single word on channel 0
    snap0 = wr_cnt0;
    send_word(0, 128'h00000003_00000002_00000001_00000000,
                 128'h00000004_00000003_00000002_00000001, w);
    vld0 = 1'b0;
    check("single_rd_first_cycle", 128'(w), 128'd0);
    repeat (4) @(posedge clk); #1;
    check("single_wr_count", 128'(wr_cnt0 - snap0), 128'd1);
    check("single_latency", 128'(last_wr_cyc0 - last_rd_cyc0), 128'd1);

    // lane wrap on channel 1, no carry between lanes
    snap1 = wr_cnt1;
    send_word(1, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'd0, w);
    send_word(1, 128'h7FFFFFFF_FFFFFFFF_7FFFFFFF_00000000,
                 128'h80000000_00000000_80000000_00000001, w);
    vld1 = 1'b0;
    repeat (4) @(posedge clk); #1;
    check("wrap_wr_count", 128'(wr_cnt1 - snap1), 128'd2);
    check("wrap_q1_drained", 128'(exp_q1.size()), 128'd0);

    // backpressure: 10 words, full0 high for 5 cycles
    snap0 = wr_cnt0;
    acc0  = 0;
    full0 = 1'b1;
    fork
      stream(0, 10, 32'h00000100);
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("bp_wr0_low", wr0, 128'd0);
          if (i >= 1) check("bp_head_held", data_out0, 128'h00000104_00000103_00000102_00000101);
        end
        check("bp_rd0_dropped", rd0, 128'd0);
        check("bp_accepted", 128'(acc0), 128'd2);
        @(posedge clk); #1;
        full0 = 1'b0;
      end
    join
    repeat (4) @(posedge clk); #1;
    check("bp_wr_count", 128'(wr_cnt0 - snap0), 128'd10);
    check("bp_q0_drained", 128'(exp_q0.size()), 128'd0);

    // throughput: 100 words on both channels at once
    snap0 = wr_cnt0;
    snap1 = wr_cnt1;
    s = cyc;
    fork
      stream(0, 100, 32'h00010000);
      stream(1, 100, 32'h00020000);
    join
    check("tput_stream_cycles", 128'(cyc - s), 128'd100);
    repeat (4) @(posedge clk); #1;
    check("tput_wr_count0", 128'(wr_cnt0 - snap0), 128'd100);
    check("tput_wr_count1", 128'(wr_cnt1 - snap1), 128'd100);
    check("tput_last_wr0", 128'(last_wr_cyc0 - s), 128'd100);
    check("tput_last_wr1", 128'(last_wr_cyc1 - s), 128'd100);

    // mid-run reset with 2 words buffered in channel 0
    full0 = 1'b1;
    stream(0, 2, 32'h00000500);
    @(negedge clk);
    check("mid_wr0_full", wr0, 128'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q0.delete();
    snap0 = wr_cnt0;
    @(negedge clk);
    check("mid_rst_wr0", wr0, 128'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_rst_wr0_after", wr0, 128'd0);
    check("mid_rst_data_out0", data_out0, 128'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    full0 = 1'b0;
    repeat (4) @(posedge clk); #1;
    check("mid_no_replay", 128'(wr_cnt0 - snap0), 128'd0);
    stream(0, 3, 32'h00000900);
    repeat (4) @(posedge clk); #1;
    check("mid_fresh_count", 128'(wr_cnt0 - snap0), 128'd3);
    check("mid_q0_drained", 128'(exp_q0.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
